// File: rtl/cbadc_control_source.sv
`default_nettype none
// ============================================================================
// Module      : cbadc_control_source
// Description : Cycle-accurate fixed-point model of a control-bounded ADC
//               analog front end. A chain of N integrators, each followed by
//               a clocked comparator whose decision feeds back +/-KAPPA into
//               its own integrator. Emits one N-bit control word per enabled
//               clock plus a batch-boundary marker every DEPTH samples.
// Optional    : define CBADC_DITHER_EN to add LFSR dither (+/- KAPPA>>4) to
//               the comparator decisions; integrator updates are unaffected.
// Ports       : clk        system clock
//               rst        synchronous active-high reset (dominates en)
//               en         sample enable; state advances only when high
//               in         signed input sample u[n] (IN_W bits)
//               out        control bits s[n]; bit k = 1 -> integrator k >= 0
//               out_valid  out was updated by this edge
//               out_last   final sample of a DEPTH-sample batch
//               ovf        sticky per-stage saturation flags
// Revision    : 1.0 - initial release
// ============================================================================
module cbadc_control_source #(
  parameter int N          = 3,
  parameter int IN_W       = 16,
  parameter int STATE_W    = 24,
  parameter int BETA_SHIFT = 0,
  parameter int KAPPA      = 16384,
  parameter int DEPTH      = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic signed [IN_W-1:0] in,
  output logic        [N-1:0]    out,
  output logic                   out_valid,
  output logic                   out_last,
  output logic        [N-1:0]    ovf
);

  // Two guard bits: x + d - f can exceed the state range by up to ~2x
  // before clamping, so the intermediate sum never wraps.
  localparam int SUM_W = STATE_W + 2;
  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Symmetric clamp limits: +/-(2^(STATE_W-1) - 1).
  localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(STATE_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(STATE_W-2){1'b0}}, 1'b1};
  localparam logic signed [SUM_W-1:0] KAPPA_S = SUM_W'(KAPPA);
  localparam logic        [CNT_W-1:0] LAST    = CNT_W'(DEPTH - 1);

  logic signed [STATE_W-1:0] r_x      [N];
  logic signed [STATE_W-1:0] w_x_next [N];
  logic                      w_clamp  [N];
  logic                      w_cmp    [N];
  logic        [CNT_W-1:0]   r_count;

`ifdef CBADC_DITHER_EN
  localparam logic signed [SUM_W-1:0] DITHER_AMP = SUM_W'(KAPPA >> 4);

  logic [15:0] r_lfsr;

  // Fibonacci LFSR, taps 16,14,13,11; advances once per enabled sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= 16'hACE1;
    end else if (en) begin
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
  end
`endif

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_stage
      logic signed [SUM_W-1:0] w_drive;
      logic signed [SUM_W-1:0] w_fb;
      logic signed [SUM_W-1:0] w_x_ext;
      logic signed [SUM_W-1:0] w_sum;
      logic                    w_hi;
      logic                    w_lo;

      // Stage 0 integrates the input; later stages integrate the previous
      // stage's registered state, so all stages update in lockstep.
      if (k == 0) begin : g_first
        assign w_drive = {{(SUM_W-IN_W){in[IN_W-1]}}, in};
      end else begin : g_chain
        assign w_drive = {{2{r_x[k-1][STATE_W-1]}}, r_x[k-1]};
      end

      assign w_x_ext = {{2{r_x[k][STATE_W-1]}}, r_x[k]};
      assign w_fb    = out[k] ? KAPPA_S : -KAPPA_S;
      assign w_sum   = w_x_ext + (w_drive >>> BETA_SHIFT) - w_fb;

      assign w_hi        = (w_sum > SAT_MAX);
      assign w_lo        = (w_sum < SAT_MIN);
      assign w_clamp[k]  = w_hi | w_lo;
      assign w_x_next[k] = w_hi ? SAT_MAX[STATE_W-1:0] :
                           w_lo ? SAT_MIN[STATE_W-1:0] :
                                  w_sum[STATE_W-1:0];

`ifdef CBADC_DITHER_EN
      logic signed [SUM_W-1:0] w_dith;
      assign w_dith   = {{2{w_x_next[k][STATE_W-1]}}, w_x_next[k]}
                      + (r_lfsr[k % 16] ? DITHER_AMP : -DITHER_AMP);
      assign w_cmp[k] = ~w_dith[SUM_W-1];
`else
      assign w_cmp[k] = ~w_x_next[k][STATE_W-1];
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        r_x[i] <= '0;
      end
      out       <= '1;   // x = 0 counts as non-negative
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      ovf       <= '0;
      r_count   <= '0;
    end else begin
      out_valid <= en;
      out_last  <= en && (r_count == LAST);
      if (en) begin
        for (int i = 0; i < N; i++) begin
          r_x[i] <= w_x_next[i];
          out[i] <= w_cmp[i];
          if (w_clamp[i]) begin
            ovf[i] <= 1'b1;
          end
        end
        r_count <= (r_count == LAST) ? '0 : r_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cbadc_control_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_cbadc_control_source
// Description : Self-checking bench for cbadc_control_source. A reference
//               model predicts each cycle's outputs; predictions are queued
//               when stimulus is driven and popped when the edge has
//               produced the DUT outputs. Scenario tasks add their own
//               targeted checks. A second instance (N=1, KAPPA=0) exercises
//               saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cbadc_control_source;

  localparam int  DEPTH = 32;
  localparam longint KAP  = 16384;
  localparam longint SMAX = 8388607;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [15:0] din;
  logic [2:0]         out;
  logic               out_valid;
  logic               out_last;
  logic [2:0]         ovf;

  logic               srst;
  logic               sen;
  logic signed [15:0] sdin;
  logic [0:0]         sout;
  logic               sout_valid;
  logic               sout_last;
  logic [0:0]         sovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] out;
    logic       valid;
    logic       last;
    logic [2:0] ovf;
  } exp_t;

  exp_t sb[$];

  // reference model state
  longint   mx [3];
  bit [2:0] mout;
  bit       mv;
  bit       ml;
  bit [2:0] movf;
  int       mcnt;

  cbadc_control_source dut (
    .clk(clk), .rst(rst), .en(en), .in(din),
    .out(out), .out_valid(out_valid), .out_last(out_last), .ovf(ovf)
  );

  cbadc_control_source #(.N(1), .KAPPA(0)) dut_sat (
    .clk(clk), .rst(srst), .en(sen), .in(sdin),
    .out(sout), .out_valid(sout_valid), .out_last(sout_last), .ovf(sovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_step(input bit r, input bit e, input int u);
    longint nx [3];
    longint d;
    longint s;
    if (r) begin
      for (int k = 0; k < 3; k++) mx[k] = 0;
      mout = 3'b111; mv = 1'b0; ml = 1'b0; movf = 3'b000; mcnt = 0;
    end else begin
      mv = e;
      ml = e && (mcnt == DEPTH - 1);
      if (e) begin
        for (int k = 0; k < 3; k++) begin
          d = (k == 0) ? longint'(u) : mx[k-1];
          s = mx[k] + d - (mout[k] ? KAP : -KAP);
          if (s > SMAX) begin
            s = SMAX; movf[k] = 1'b1;
          end else if (s < -SMAX) begin
            s = -SMAX; movf[k] = 1'b1;
          end
          nx[k] = s;
        end
        for (int k = 0; k < 3; k++) begin
          mx[k]   = nx[k];
          mout[k] = (nx[k] >= 0);
        end
        mcnt = (mcnt == DEPTH - 1) ? 0 : mcnt + 1;
      end
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and queue the prediction
  // for the following rising edge.
  task automatic drive(input bit r, input bit e, input int u);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; din = 16'(u);
    model_step(r, e, u);
    x.out = mout; x.valid = mv; x.last = ml; x.ovf = movf;
    sb.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare predictions once the edge has updated the outputs.
  always @(posedge clk) begin : mon
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (out !== e.out) begin
        errors++; $display("FAIL sb_out got %b exp %b at %0t", out, e.out, $time);
      end
      checks++;
      if (out_valid !== e.valid) begin
        errors++; $display("FAIL sb_valid got %b exp %b at %0t", out_valid, e.valid, $time);
      end
      checks++;
      if (out_last !== e.last) begin
        errors++; $display("FAIL sb_last got %b exp %b at %0t", out_last, e.last, $time);
      end
      checks++;
      if (ovf !== e.ovf) begin
        errors++; $display("FAIL sb_ovf got %b exp %b at %0t", ovf, e.ovf, $time);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1234);
      tick();
      checks++;
      if (out !== 3'b111 || out_valid !== 1'b0 || out_last !== 1'b0 || ovf !== 3'b000) begin
        errors++;
        $display("FAIL reset_state got out=%b v=%b l=%b ovf=%b exp 111/0/0/000",
                 out, out_valid, out_last, ovf);
      end
    end
  endtask

  task automatic test_zero_input();
    drive(1'b0, 1'b1, 0);
    tick();
    checks++;
    if (out !== 3'b000 || out_valid !== 1'b1) begin
      errors++; $display("FAIL zero_step1 got out=%b v=%b exp 000/1", out, out_valid);
    end
    drive(1'b0, 1'b1, 0);
    tick();
    checks++;
    if (out !== 3'b001 || out_valid !== 1'b1) begin
      errors++; $display("FAIL zero_step2 got out=%b v=%b exp 001/1", out, out_valid);
    end
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 0);
  endtask

  task automatic test_patterns();
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, 20000);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, -20000);
    for (int i = 0; i < 60; i++) begin
      drive(1'b0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 60000)) - 30000);
    end
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 32767);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, -32768);
  endtask

  task automatic test_framing();
    logic [2:0] held;
    drive(1'b1, 1'b0, 0);
    for (int i = 1; i <= 70; i++) begin
      drive(1'b0, 1'b1, 0);
      tick();
      checks++;
      if (out_last !== ((i == 32) || (i == 64))) begin
        errors++; $display("FAIL frame_last sample %0d got %b", i, out_last);
      end
      if (i == 40) begin
        held = out;
        for (int g = 0; g < 5; g++) begin
          drive(1'b0, 1'b0, 0);
          tick();
          checks++;
          if (out_valid !== 1'b0 || out_last !== 1'b0 || out !== held) begin
            errors++;
            $display("FAIL frame_gap cycle %0d got v=%b l=%b out=%b exp 0/0/%b",
                     g, out_valid, out_last, out, held);
          end
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    drive(1'b1, 1'b0, 0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, int'($urandom_range(0, 16000)) - 8000);
    drive(1'b1, 1'b1, 0);
    for (int i = 1; i <= 40; i++) begin
      drive(1'b0, 1'b1, 0);
      tick();
      if (i == 1) begin
        checks++;
        if (out !== 3'b000 || out_valid !== 1'b1) begin
          errors++; $display("FAIL midrst_step1 got out=%b v=%b exp 000/1", out, out_valid);
        end
      end
      if (i == 2) begin
        checks++;
        if (out !== 3'b001) begin
          errors++; $display("FAIL midrst_step2 got out=%b exp 001", out);
        end
      end
      checks++;
      if (out_last !== (i == 32)) begin
        errors++; $display("FAIL midrst_last sample %0d got %b", i, out_last);
      end
    end
  endtask

  task automatic test_stability();
    logic [2:0] prev;
    int last_tog [3];
    int max_gap  [3];
    drive(1'b1, 1'b0, 0);
    tick();
    prev = out;
    for (int k = 0; k < 3; k++) begin
      last_tog[k] = 0; max_gap[k] = 0;
    end
    for (int i = 1; i <= 4096; i++) begin
      drive(1'b0, 1'b1, (((i - 1) / 8) % 2 == 0) ? 8192 : -8192);
      tick();
      for (int k = 0; k < 3; k++) begin
        if (out[k] !== prev[k]) last_tog[k] = i;
        if (i - last_tog[k] > max_gap[k]) max_gap[k] = i - last_tog[k];
      end
      prev = out;
    end
    checks++;
    if (ovf !== 3'b000) begin
      errors++; $display("FAIL stab_ovf got %b exp 000", ovf);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (max_gap[k] >= 64) begin
        errors++; $display("FAIL stab_toggle bit %0d longest run %0d samples, exp < 64", k, max_gap[k]);
      end
    end
  endtask

  task automatic sat_drive(input bit r, input bit e, input int u);
    @(negedge clk);
    srst = r; sen = e; sdin = 16'(u);
    tick();
  endtask

  task automatic test_saturation();
    sat_drive(1'b1, 1'b0, 0);
    for (int i = 1; i <= 257; i++) begin
      sat_drive(1'b0, 1'b1, 32767);
      if (i == 1 || i == 256) begin
        checks++;
        if (sovf !== 1'b0 || sout !== 1'b1) begin
          errors++; $display("FAIL sat_pre edge %0d got ovf=%b out=%b exp 0/1", i, sovf, sout);
        end
      end
      if (i == 257) begin
        checks++;
        if (sovf !== 1'b1) begin
          errors++; $display("FAIL sat_clamp edge 257 got ovf=%b exp 1", sovf);
        end
      end
    end
    for (int i = 0; i < 20; i++) begin
      sat_drive(1'b0, 1'b1, -32767);
    end
    checks++;
    if (sovf !== 1'b1) begin
      errors++; $display("FAIL sat_sticky got ovf=%b exp 1", sovf);
    end
    sat_drive(1'b1, 1'b0, 0);
    checks++;
    if (sovf !== 1'b0 || sout !== 1'b1) begin
      errors++; $display("FAIL sat_rst got ovf=%b out=%b exp 0/1", sovf, sout);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; din = '0;
    srst = 1'b1; sen = 1'b0; sdin = '0;
    test_reset();
    test_zero_input();
    test_patterns();
    test_framing();
    test_mid_reset();
    test_stability();
    drive(1'b0, 1'b0, 0);
    test_saturation();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain got %0d pending exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
